// File: rtl/relu_maxpool22.sv
// relu_maxpool22: streaming ReLU followed by 2x2/stride-2 max-pool.
// Consumes one signed conv result per enabled cycle in raster order and
// emits one requantised, saturated pooled value per 2x2 window. A half-row
// line buffer carries the even-row pair maxima over to the following odd row.
module relu_maxpool22 #(
    parameter int IN_WIDTH  = 32,
    parameter int BIT_WIDTH = 8,
    parameter int CONV_SIZE = 10,
    parameter int SHIFT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic        [BIT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    output logic                        frame_done
);

    localparam int HALF = CONV_SIZE / 2;
    localparam int CW   = (CONV_SIZE > 2) ? $clog2(CONV_SIZE) : 1;
    localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0]       COL_LAST = CW'(CONV_SIZE - 1);
    localparam logic [IN_WIDTH-1:0] SAT_MAX  = IN_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [CW-1:0]        row_q, row_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [IN_WIDTH-1:0]  linebuf_q [HALF];
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [IN_WIDTH-1:0]  relu;
    logic [IN_WIDTH-1:0]  pair_max;
    logic [IN_WIDTH-1:0]  pool_max;
    logic [IN_WIDTH-1:0]  shifted;
    logic [KW-1:0]        k;
    logic                 col_last, row_last, col_odd, row_odd;
    logic                 lb_we;

    // Datapath: ReLU, pair maximum, window maximum, requantise and saturate
    always_comb begin
        relu     = in_data[IN_WIDTH-1] ? '0 : IN_WIDTH'(in_data);
        pair_max = (hold_q > relu) ? hold_q : relu;
        k        = KW'(col_q >> 1);
        pool_max = (linebuf_q[k] > pair_max) ? linebuf_q[k] : pair_max;
        shifted  = pool_max >> SHIFT;
    end

    // Next-state: position counters, hold register, line-buffer write, outputs
    always_comb begin
        col_last     = (col_q == COL_LAST);
        row_last     = (row_q == COL_LAST);
        col_odd      = col_q[0];
        row_odd      = row_q[0];
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        lb_we        = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_data_d   = out_data_q;
        if (en) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            if (!col_odd) begin
                hold_d = relu;
            end else if (!row_odd) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                frame_done_d = col_last && row_last;
                out_data_d   = (shifted > SAT_MAX) ? SAT_MAX[BIT_WIDTH-1:0]
                                                   : shifted[BIT_WIDTH-1:0];
            end
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int unsigned i = 0; i < HALF; i++) begin
                linebuf_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (lb_we) begin
                linebuf_q[k] <= pair_max;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
